// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and control-flow sequencer for a short in-order pipeline. Detects
// read-after-write hazards against the EX and WB stage destinations, inserts
// bubbles after branch/flush-class instructions and interrupt accepts, and
// drives the PC / fetch / decode control strobes.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous active-high reset
//   src_addr      packed source register addresses, port i at [i*REG_AW +: REG_AW]
//   src_valid     per-port source-in-use flags
//   ex_dst/_en    EX-stage destination register and write enable
//   wb_dst/_en    WB-stage destination register and write enable
//   instr_type    decode class: 1-5 branch, 6-9 call/return/flush, else normal
//   branch_taken  resolved branch direction
//   interrupt     level interrupt request
//   fetch_stall   hold fetch latch and PC
//   dec_nop       replace decode output with a NOP
//   pc_load       load PC from branch target
//   pc_reset      force PC to the reset vector
//   int_ack       one-cycle interrupt accept pulse (also selects the vector)
//   busy          sequencer is not in its CHECK state
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_AW        = 5,
  parameter int NUM_SRC       = 2,
  parameter int FLUSH_DEPTH   = 2,
  parameter int INT_DEPTH     = 2,
  parameter int ZERO_REG_SAFE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_dst_en,
  input  logic [REG_AW-1:0]         wb_dst,
  input  logic                      wb_dst_en,
  input  logic [3:0]                instr_type,
  input  logic                      branch_taken,
  input  logic                      interrupt,
  output logic                      fetch_stall,
  output logic                      dec_nop,
  output logic                      pc_load,
  output logic                      pc_reset,
  output logic                      int_ack,
  output logic                      busy
);

  localparam int MAX_DEPTH = (FLUSH_DEPTH > INT_DEPTH) ? FLUSH_DEPTH : INT_DEPTH;
  localparam int CNT_W     = $clog2(MAX_DEPTH + 1);

  // Counter load values: the counter holds "remaining bubbles minus one", so
  // the state exits on the cycle after it reaches zero.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] INT_LOAD   = CNT_W'(INT_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_CHECK  = 3'd0,
    ST_RAW_EX = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_INT    = 3'd3,
    ST_RESET  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             int_pend_reg, int_pend_next;

  // --------------------------------------------------------------------------
  // RAW hazard detection, one comparator pair per source port
  // --------------------------------------------------------------------------
  logic [NUM_SRC-1:0] ex_match;
  logic [NUM_SRC-1:0] wb_match;
  logic               ex_zero;
  logic               wb_zero;
  logic               raw_ex;
  logic               raw_wb;

  // Register 0 is hard-wired, so writes to it never produce a real dependency.
  assign ex_zero = (ZERO_REG_SAFE != 0) && (ex_dst == '0);
  assign wb_zero = (ZERO_REG_SAFE != 0) && (wb_dst == '0);

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] addr;
      assign addr         = src_addr[gi*REG_AW +: REG_AW];
      assign ex_match[gi] = src_valid[gi] && ex_dst_en && (addr == ex_dst) && !ex_zero;
      assign wb_match[gi] = src_valid[gi] && wb_dst_en && (addr == wb_dst) && !wb_zero;
    end
  endgenerate

  assign raw_ex = |ex_match;
  assign raw_wb = |wb_match;

  // --------------------------------------------------------------------------
  // Instruction class decode
  // --------------------------------------------------------------------------
  logic is_branch;
  logic is_flush_class;
  logic int_req;

  assign is_branch      = (instr_type >= 4'd1) && (instr_type <= 4'd5);
  assign is_flush_class = (instr_type >= 4'd6) && (instr_type <= 4'd9);
  assign int_req        = interrupt || int_pend_reg;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RESET;
      cnt_reg      <= FLUSH_LOAD;
      int_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      int_pend_reg <= int_pend_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    int_pend_next = int_pend_reg;
    fetch_stall   = 1'b0;
    dec_nop       = 1'b0;
    int_ack       = 1'b0;

    case (state_reg)
      ST_CHECK: begin
        if (int_req) begin
          // Interrupt outranks every hazard; a coincident branch is simply
          // squashed by the interrupt bubbles.
          state_next    = ST_INT;
          cnt_next      = INT_LOAD;
          int_ack       = 1'b1;
          dec_nop       = 1'b1;
          int_pend_next = 1'b0;
        end else if (raw_ex) begin
          state_next  = ST_RAW_EX;
          fetch_stall = 1'b1;
        end else if (raw_wb) begin
          // WB hazard clears by itself next cycle; stall in place and re-check.
          fetch_stall = 1'b1;
        end else if (is_branch || is_flush_class) begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_LOAD;
          dec_nop    = 1'b1;
        end
      end

      ST_RAW_EX: begin
        fetch_stall = 1'b1;
        state_next  = ST_CHECK;
        if (interrupt) int_pend_next = 1'b1;
      end

      ST_FLUSH, ST_INT, ST_RESET: begin
        dec_nop = 1'b1;
        if (interrupt) int_pend_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = ST_CHECK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_RESET;
        cnt_next   = FLUSH_LOAD;
        dec_nop    = 1'b1;
      end
    endcase

    // Reset masks the strobes combinationally so the pipeline is quiesced
    // from the very first reset cycle, before the state register follows.
    if (reset) begin
      fetch_stall = 1'b0;
      dec_nop     = 1'b1;
      int_ack     = 1'b0;
    end
  end

  assign pc_load  = branch_taken && !reset && !fetch_stall;
  assign pc_reset = reset;
  assign busy     = (state_reg != ST_CHECK) || reset;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;

  // Default-parameter instance
  logic [9:0] src_addr;
  logic [1:0] src_valid;
  logic [4:0] ex_dst, wb_dst;
  logic       ex_dst_en, wb_dst_en;
  logic [3:0] instr_type;
  logic       branch_taken, interrupt;
  logic       fetch_stall, dec_nop, pc_load, pc_reset, int_ack, busy;

  // NUM_SRC=3, FLUSH_DEPTH=4 instance
  logic [14:0] d2_src_addr;
  logic [2:0]  d2_src_valid;
  logic [4:0]  d2_ex_dst, d2_wb_dst;
  logic        d2_ex_dst_en, d2_wb_dst_en;
  logic [3:0]  d2_instr_type;
  logic        d2_branch_taken, d2_interrupt;
  logic        d2_fetch_stall, d2_dec_nop, d2_pc_load, d2_pc_reset, d2_int_ack, d2_busy;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .src_addr(src_addr), .src_valid(src_valid),
    .ex_dst(ex_dst), .ex_dst_en(ex_dst_en),
    .wb_dst(wb_dst), .wb_dst_en(wb_dst_en),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .fetch_stall(fetch_stall), .dec_nop(dec_nop), .pc_load(pc_load),
    .pc_reset(pc_reset), .int_ack(int_ack), .busy(busy)
  );

  pipeline_hazard_ctrl #(.NUM_SRC(3), .FLUSH_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset),
    .src_addr(d2_src_addr), .src_valid(d2_src_valid),
    .ex_dst(d2_ex_dst), .ex_dst_en(d2_ex_dst_en),
    .wb_dst(d2_wb_dst), .wb_dst_en(d2_wb_dst_en),
    .instr_type(d2_instr_type), .branch_taken(d2_branch_taken), .interrupt(d2_interrupt),
    .fetch_stall(d2_fetch_stall), .dec_nop(d2_dec_nop), .pc_load(d2_pc_load),
    .pc_reset(d2_pc_reset), .int_ack(d2_int_ack), .busy(d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sa;
    logic [1:0] sv;
    logic [4:0] exd;
    logic       exe;
    logic [4:0] wbd;
    logic       wbe;
    logic [3:0] it;
    logic       bt;
    logic       irq;
    logic       e_stall;
    logic       e_nop;
    logic       e_load;
    logic       e_ack;
    logic       e_busy_next;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_addr = '0; src_valid = '0; ex_dst = '0; ex_dst_en = 1'b0;
    wb_dst = '0; wb_dst_en = 1'b0; instr_type = '0; branch_taken = 1'b0; interrupt = 1'b0;
  endtask

  // Returns at a negedge where both instances report CHECK.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || d2_busy) && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || d2_busy) begin
      errors++;
      $display("FAIL %s: busy=%b d2_busy=%b after %0d cycles, expected 0", name, busy, d2_busy, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //              sa                 sv     exd   exe   wbd   wbe   it    bt    irq   stall nop   load  ack   bnext
    vecs[0]  = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{{5'd0, 5'd3},       2'b01, 5'd3, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{{5'd5, 5'd0},       2'b10, 5'd0, 1'b0, 5'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{{5'd0, 5'd0},       2'b01, 5'd0, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{{5'd0, 5'd3},       2'b00, 5'd3, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{{5'd0, 5'd3},       2'b01, 5'd3, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{{5'd9, 5'd0},       2'b10, 5'd9, 1'b1, 5'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{{5'd0, 5'd3},       2'b01, 5'd3, 1'b1, 5'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{{5'd6, 5'd0},       2'b10, 5'd0, 1'b0, 5'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{{5'd0, 5'd0},       2'b01, 5'd0, 1'b0, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{{5'd4, 5'd8},       2'b11, 5'd8, 1'b1, 5'd4, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{{5'd0, 5'd2},       2'b01, 5'd0, 1'b0, 5'd2, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{10'h000,            2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    idle_inputs();
    d2_src_addr = '0; d2_src_valid = '0; d2_ex_dst = '0; d2_ex_dst_en = 1'b0;
    d2_wb_dst = '0; d2_wb_dst_en = 1'b0; d2_instr_type = '0; d2_branch_taken = 1'b0; d2_interrupt = 1'b0;
    reset = 1'b1;
    branch_taken = 1'b1;

    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst pc_reset", pc_reset, 1'b1);
    chk("rst dec_nop", dec_nop, 1'b1);
    chk("rst fetch_stall", fetch_stall, 1'b0);
    chk("rst pc_load", pc_load, 1'b0);
    chk("rst int_ack", int_ack, 1'b0);
    chk("rst busy", busy, 1'b1);
    $display("reset: pc_reset=%b dec_nop=%b busy=%b", pc_reset, dec_nop, busy);
    tick();
    reset = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("rst cd1 busy", busy, 1'b1);
    chk("rst cd1 dec_nop", dec_nop, 1'b1);
    chk("rst cd1 pc_reset", pc_reset, 1'b0);
    tick();
    @(negedge clk);
    chk("rst cd2 busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("rst done busy", busy, 1'b0);
    chk("rst done dec_nop", dec_nop, 1'b0);
    wait_idle("post reset idle");

    // ---------------- Single-cycle vector table from CHECK ----------------
    for (int i = 0; i < NVEC; i++) begin
      tick();
      src_addr = vecs[i].sa; src_valid = vecs[i].sv;
      ex_dst = vecs[i].exd; ex_dst_en = vecs[i].exe;
      wb_dst = vecs[i].wbd; wb_dst_en = vecs[i].wbe;
      instr_type = vecs[i].it; branch_taken = vecs[i].bt; interrupt = vecs[i].irq;
      @(negedge clk);
      chk($sformatf("v%0d fetch_stall", i), fetch_stall, vecs[i].e_stall);
      chk($sformatf("v%0d dec_nop", i), dec_nop, vecs[i].e_nop);
      chk($sformatf("v%0d pc_load", i), pc_load, vecs[i].e_load);
      chk($sformatf("v%0d int_ack", i), int_ack, vecs[i].e_ack);
      chk($sformatf("v%0d busy", i), busy, 1'b0);
      $display("vec %0d: stall=%b nop=%b load=%b ack=%b", i, fetch_stall, dec_nop, pc_load, int_ack);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d busy_next", i), busy, vecs[i].e_busy_next);
      idle_inputs();
      wait_idle($sformatf("v%0d recover", i));
    end

    // ---------------- RAW on EX: stall two cycles ----------------
    tick();
    src_addr = {5'd0, 5'd3}; src_valid = 2'b01; ex_dst = 5'd3; ex_dst_en = 1'b1;
    @(negedge clk);
    chk("rawex c0 stall", fetch_stall, 1'b1);
    tick();
    @(negedge clk);
    chk("rawex c1 stall", fetch_stall, 1'b1);
    chk("rawex c1 busy", busy, 1'b1);
    tick();
    ex_dst_en = 1'b0;
    @(negedge clk);
    chk("rawex c2 stall", fetch_stall, 1'b0);
    chk("rawex c2 busy", busy, 1'b0);
    $display("seq rawex: third cycle stall=%b busy=%b", fetch_stall, busy);
    idle_inputs();
    wait_idle("rawex recover");

    // ---------------- Branch flush: three NOP cycles ----------------
    tick();
    instr_type = 4'd2;
    @(negedge clk);
    chk("br c0 nop", dec_nop, 1'b1);
    chk("br c0 busy", busy, 1'b0);
    tick();
    instr_type = 4'd0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("br c%0d nop", c), dec_nop, 1'b1);
      chk($sformatf("br c%0d busy", c), busy, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("br c3 nop", dec_nop, 1'b0);
    chk("br c3 busy", busy, 1'b0);
    $display("seq branch: flush complete nop=%b busy=%b", dec_nop, busy);
    wait_idle("br recover");

    // ---------------- Interrupt during FLUSH becomes pending ----------------
    tick();
    instr_type = 4'd2;
    @(negedge clk);
    tick();
    instr_type = 4'd0;
    interrupt = 1'b1;
    @(negedge clk);
    chk("pend c1 ack", int_ack, 1'b0);
    tick();
    interrupt = 1'b0;
    @(negedge clk);
    chk("pend c2 ack", int_ack, 1'b0);
    chk("pend c2 nop", dec_nop, 1'b1);
    tick();
    @(negedge clk);
    chk("pend c3 ack", int_ack, 1'b1);
    chk("pend c3 nop", dec_nop, 1'b1);
    chk("pend c3 busy", busy, 1'b0);
    tick();
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("pend c%0d nop", c), dec_nop, 1'b1);
      chk($sformatf("pend c%0d ack", c), int_ack, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("pend c6 nop", dec_nop, 1'b0);
    chk("pend c6 busy", busy, 1'b0);
    $display("seq pend: int serviced after flush");
    wait_idle("pend recover");

    // ---------------- Reset during INT, interrupt pending through RESET ----------------
    tick();
    interrupt = 1'b1;
    @(negedge clk);
    chk("rint c0 ack", int_ack, 1'b1);
    tick();
    interrupt = 1'b0;
    reset = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    chk("rint c1 pc_reset", pc_reset, 1'b1);
    chk("rint c1 nop", dec_nop, 1'b1);
    chk("rint c1 stall", fetch_stall, 1'b0);
    chk("rint c1 load", pc_load, 1'b0);
    chk("rint c1 busy", busy, 1'b1);
    tick();
    reset = 1'b0;
    branch_taken = 1'b0;
    interrupt = 1'b1;
    @(negedge clk);
    chk("rint c2 pc_reset", pc_reset, 1'b0);
    chk("rint c2 nop", dec_nop, 1'b1);
    chk("rint c2 busy", busy, 1'b1);
    chk("rint c2 ack", int_ack, 1'b0);
    tick();
    interrupt = 1'b0;
    @(negedge clk);
    chk("rint c3 nop", dec_nop, 1'b1);
    chk("rint c3 busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("rint c4 busy", busy, 1'b0);
    chk("rint c4 ack", int_ack, 1'b1);
    $display("seq reset-in-int: busy=%b ack=%b at first CHECK", busy, int_ack);
    wait_idle("rint recover");

    // ---------------- Interrupt held with reset is discarded ----------------
    tick();
    reset = 1'b1;
    interrupt = 1'b1;
    @(negedge clk);
    chk("rdrop c0 ack", int_ack, 1'b0);
    tick();
    reset = 1'b0;
    interrupt = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rdrop c3 busy", busy, 1'b0);
    chk("rdrop c3 ack", int_ack, 1'b0);
    chk("rdrop c3 nop", dec_nop, 1'b0);
    $display("seq reset-drop: ack=%b", int_ack);
    wait_idle("rdrop recover");

    // ---------------- Second instance: WB hazard on port 2 plus flush-class ----------------
    tick();
    d2_src_addr = {5'd7, 5'd0, 5'd0}; d2_src_valid = 3'b100;
    d2_wb_dst = 5'd7; d2_wb_dst_en = 1'b1; d2_instr_type = 4'd6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("d2 hold%0d stall", c), d2_fetch_stall, 1'b1);
      chk($sformatf("d2 hold%0d nop", c), d2_dec_nop, 1'b0);
      chk($sformatf("d2 hold%0d busy", c), d2_busy, 1'b0);
      tick();
    end
    d2_wb_dst_en = 1'b0;
    @(negedge clk);
    chk("d2 detect stall", d2_fetch_stall, 1'b0);
    chk("d2 detect nop", d2_dec_nop, 1'b1);
    chk("d2 detect busy", d2_busy, 1'b0);
    tick();
    d2_instr_type = 4'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("d2 flush%0d nop", c), d2_dec_nop, 1'b1);
      chk($sformatf("d2 flush%0d busy", c), d2_busy, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("d2 end nop", d2_dec_nop, 1'b0);
    chk("d2 end busy", d2_busy, 1'b0);
    $display("seq d2: five NOP cycles then nop=%b busy=%b", d2_dec_nop, d2_busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
